// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and small op-classification helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, flush, a_in, b_in,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, flush, a_in, b_in,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: abs() of signed operands on entry,
// sign restoration of product/quotient/remainder on exit.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);
    assign res = neg ? ('0 - val) : val;
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO: WIDTH-step
// shift-add multiply and restoring divide, plus MTHI/MTLO writes.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_unit_if.slave  md
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e          state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               op_mul_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               div0_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               sgn;
    logic               accept;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH:0]   div_shift;

    assign sgn     = is_signed_op(md.op);
    assign accept  = (state == IDLE) && md.start && !md.flush;
    assign md.busy = (state != IDLE);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .val(md.a_in), .neg(sgn & md.a_in[WIDTH-1]), .res(a_abs)
    );
    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .val(md.b_in), .neg(sgn & md.b_in[WIDTH-1]), .res(b_abs)
    );
    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val(acc_q), .neg(neg_q), .res(prod_fix)
    );
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quot (
        .val(acc_q[WIDTH-1:0]), .neg(neg_q), .res(quot_fix)
    );
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .val(acc_q[2*WIDTH-1:WIDTH]), .neg(rem_neg_q), .res(rem_fix)
    );

    // One iteration. Multiply: acc = {partial, multiplier}, add then shift right.
    // Divide: acc = {remainder, dividend/quotient}, shift left then trial-subtract.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, 1'b0};
        div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        if (op_mul_q)
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!div_trial[WIDTH])
            acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_step = {div_shift[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_muldiv(md.op)) state_next = CALC;
            CALC:    if (md.flush) state_next = IDLE;
                     else if (cnt == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            op_mul_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_muldiv(md.op)) begin
                        cnt       <= CNT_W'(WIDTH);
                        op_mul_q  <= is_mul(md.op);
                        neg_q     <= sgn & (md.a_in[WIDTH-1] ^ md.b_in[WIDTH-1]);
                        rem_neg_q <= sgn & md.a_in[WIDTH-1];
                        div0_q    <= (md.b_in == '0);
                        a_raw_q   <= md.a_in;
                        opnd_q    <= is_mul(md.op) ? a_abs : b_abs;
                        acc_q     <= {{WIDTH{1'b0}}, (is_mul(md.op) ? b_abs : a_abs)};
                    end else if (accept && md.op == MD_MTHI) begin
                        hi_q <= md.a_in;
                    end else if (accept && md.op == MD_MTLO) begin
                        lo_q <= md.a_in;
                    end
                end
                CALC: begin
                    if (!md.flush) begin
                        acc_q <= acc_step;
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                FINISH: begin
                    // Divide-by-zero reports the raw dividend regardless of signedness.
                    if (!md.flush) begin
                        done_q <= 1'b1;
                        if (op_mul_q) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (div0_q) begin
                            lo_q <= '1;
                            hi_q <= a_raw_q;
                        end else begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(32)) md();
    ex_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .md(md));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one completed op, straight from the ISA rules.
    function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            MD_MULT:  begin sp = longint'(sa) * longint'(sb); {m_hi, m_lo} = sp; end
            MD_MULTU: begin up = 64'(a) * 64'(b); {m_hi, m_lo} = up; end
            MD_DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else if (a == 32'h8000_0000 && sb == -1) begin m_lo = 32'h8000_0000; m_hi = 0; end
                else begin m_lo = sa / sb; m_hi = sa % sb; end
            end
            MD_DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int busy_cnt;
        int cyc;
        md.start = 1'b1; md.op = op; md.a_in = a; md.b_in = b;
        tick();
        md.start = 1'b0; md.a_in = $urandom; md.b_in = $urandom;
        model_apply(op, a, b);
        if (is_muldiv(op)) begin
            busy_cnt = int'(md.busy);
            cyc = 0;
            while (!md.done && cyc < 40) begin
                tick();
                cyc++;
                busy_cnt += int'(md.busy);
            end
            chk({tag, "_latency"}, 64'(cyc), 64'd33);
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
            chk({tag, "_hi"}, 64'(md.hi), 64'(m_hi));
            chk({tag, "_lo"}, 64'(md.lo), 64'(m_lo));
            tick();
            chk({tag, "_done_single"}, 64'(md.done), 64'd0);
        end else begin
            chk({tag, "_busy"}, 64'(md.busy), 64'd0);
            chk({tag, "_done"}, 64'(md.done), 64'd0);
            chk({tag, "_hi"}, 64'(md.hi), 64'(m_hi));
            chk({tag, "_lo"}, 64'(md.lo), 64'(m_lo));
        end
    endtask

    initial begin
        int          done_cnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        md.start = 1'b0; md.op = '0; md.flush = 1'b0; md.a_in = '0; md.b_in = '0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_hi", 64'(md.hi), 64'd0);
        chk("reset_lo", 64'(md.lo), 64'd0);
        chk("reset_busy", 64'(md.busy), 64'd0);
        chk("reset_done", 64'(md.done), 64'd0);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_const", 64'(md.hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_max_lo_const", 64'(md.lo), 64'h0000_0000_0000_0001);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", MD_DIVU, 32'h1234_5678, 32'd0);
        run_op("div_zero_neg", MD_DIV, 32'h8765_4321, 32'd0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", 64'(md.lo), 64'h0000_0000_8000_0000);
        run_op("mult_minint", MD_MULT, 32'h8000_0000, 32'h8000_0000);

        // Start while busy must be ignored.
        md.start = 1'b1; md.op = MD_MULTU; md.a_in = 32'd6; md.b_in = 32'd7;
        tick();
        md.start = 1'b0;
        repeat (4) tick();
        md.start = 1'b1; md.op = MD_DIVU; md.a_in = 32'd100; md.b_in = 32'd3;
        tick();
        md.start = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            tick();
            done_cnt += int'(md.done);
        end
        chk("restart_done_count", 64'(done_cnt), 64'd1);
        chk("restart_hi", 64'(md.hi), 64'd0);
        chk("restart_lo", 64'(md.lo), 64'd42);
        chk("restart_busy", 64'(md.busy), 64'd0);
        m_hi = 32'd0; m_lo = 32'd42;

        // Flush mid-CALC leaves HI/LO untouched and produces no done.
        run_op("mthi", MD_MTHI, 32'hAAAA_0000, $urandom);
        run_op("mtlo", MD_MTLO, 32'h0000_5555, $urandom);
        md.start = 1'b1; md.op = MD_MULT; md.a_in = 32'd123; md.b_in = 32'd456;
        tick();
        md.start = 1'b0;
        repeat (10) tick();
        md.flush = 1'b1;
        tick();
        md.flush = 1'b0;
        chk("flush_busy", 64'(md.busy), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            tick();
            done_cnt += int'(md.done);
        end
        chk("flush_no_done", 64'(done_cnt), 64'd0);
        chk("flush_hi", 64'(md.hi), 64'hAAAA_0000);
        chk("flush_lo", 64'(md.lo), 64'h0000_5555);

        // Flush on the FINISH cycle also suppresses the write.
        md.start = 1'b1; md.op = MD_DIVU; md.a_in = 32'd99; md.b_in = 32'd4;
        tick();
        md.start = 1'b0;
        repeat (32) tick();
        chk("fin_busy", 64'(md.busy), 64'd1);
        md.flush = 1'b1;
        tick();
        md.flush = 1'b0;
        chk("fin_flush_done", 64'(md.done), 64'd0);
        chk("fin_flush_busy", 64'(md.busy), 64'd0);
        chk("fin_flush_hi", 64'(md.hi), 64'hAAAA_0000);
        chk("fin_flush_lo", 64'(md.lo), 64'h0000_5555);

        // Flush in IDLE blocks a start in the same cycle.
        md.start = 1'b1; md.flush = 1'b1; md.op = MD_MTHI; md.a_in = 32'h1111_2222;
        tick();
        chk("idle_flush_mthi", 64'(md.hi), 64'hAAAA_0000);
        md.op = MD_MULT;
        tick();
        md.start = 1'b0; md.flush = 1'b0;
        chk("idle_flush_mult", 64'(md.busy), 64'd0);

        // Reset mid-CALC clears everything.
        md.start = 1'b1; md.op = MD_DIV; md.a_in = 32'd1000; md.b_in = 32'd7;
        tick();
        md.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_hi", 64'(md.hi), 64'd0);
        chk("midreset_lo", 64'(md.lo), 64'd0);
        chk("midreset_busy", 64'(md.busy), 64'd0);
        chk("midreset_done", 64'(md.done), 64'd0);
        m_hi = '0; m_lo = '0;

        run_op("mtlo_dead", MD_MTLO, 32'hDEAD_BEEF, $urandom);
        tick();
        chk("mtlo_dead_done_after", 64'(md.done), 64'd0);
        run_op("undef6", 3'b110, $urandom, $urandom);
        run_op("undef7", 3'b111, $urandom, $urandom);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage. It takes the forwarded operands (post-forwarding A and B values) and performs MIPS MULT/MULTU/DIV/DIVU into architectural HI/LO registers; it also handles MTHI/MTLO. It asserts busy so the hazard unit stalls MFHI/MFLO and any new mul/div until the result is committed. It sits alongside the ALU and is fed by the operand forwarding muxes.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  EX-stage instruction valid with a muldiv op; sampled only when idle
op  in  3  operation code (encodings in package)
flush  in  1  abort in-flight operation (branch/exception flush)
a_in  in  WIDTH  forwarded operand A (rs)
b_in  in  WIDTH  forwarded operand B (rt)
busy  out  1  high while state != IDLE (combinational from state)
done  out  1  one-cycle pulse, registered, when HI/LO updated by mul/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (sync, active-high): state=IDLE; hi=0, lo=0, done=0, internal accumulators 0. Reset overrides start and flush in the same cycle.
- States: IDLE, CALC, FINISH.
- IDLE + start + op in {MULT,MULTU,DIV,DIVU} at edge E0: latch |a|,|b| (abs only for signed ops), result-sign flags, op, and a 6-bit counter = WIDTH; go to CALC.
- CALC: one iteration per edge, E1..E32. Multiply uses shift-add on a 2*WIDTH product. Divide uses restoring divide: shift remainder, trial-subtract, set quotient bit. Counter decrements; at 1, go to FINISH.
- FINISH (edge E33): apply sign fixups and write hi/lo; done=1 for exactly this cycle; go to IDLE. busy is high for 33 cycles, after E0 through E32.
- Multiply: {hi,lo} = full 64-bit product. Signed product is negated if sign(a)^sign(b).
- Divide: lo=quotient, hi=remainder. Signed quotient is negated if sign(a)^sign(b). Remainder takes the sign of the dividend.
- Divide by zero: runs full latency; lo=all-ones, hi=a_in as latched (raw, unsigned view).
- Signed 0x80000000 / -1: lo=0x80000000, hi=0 (32-bit wrap, no trap).
- MTHI/MTLO: with IDLE+start, the write to hi (or lo) with a_in occurs at that edge. No busy, no done.
- start while busy: ignored. Hazard unit guarantees stall; the block must not restart or corrupt state.
- flush while CALC/FINISH: return to IDLE next edge; hi/lo unchanged; no done. flush in IDLE also blocks start that cycle.
- Undefined op codes with start: no effect.
- hi/lo hold values at all times except on the writes above.

Decomposition:
- Shared package muldiv_pkg: op encodings MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101; state encodings IDLE/CALC/FINISH.
- One natural sub-module: muldiv_signfix, a combinational abs/negate helper used at latch and at FINISH.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 -> busy 33 cycles; at E33 hi=0xFFFFFFFE, lo=0x00000001, done pulses one cycle.
- MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 6*7 started; at E5 pulse start with DIVU 100/3 -> ignored; final hi=0, lo=42, single done pulse.
- Preload via MTHI a=0xAAAA0000 and MTLO a=0x5555; start MULT; flush at E10 -> IDLE at E11, busy=0, hi=0xAAAA0000, lo=0x5555, no done. Then reset mid-CALC -> hi=lo=0, busy=0 next edge.
- MTLO a=0xDEADBEEF while idle -> lo=0xDEADBEEF on the same edge, busy never asserts, done stays 0.
